// File: rtl/seg7_to_hex_encoder.sv
// -----------------------------------------------------------------------------
// seg7_to_hex_encoder
//
// Watches an active-low seven-segment bus and recovers the hex digit it shows.
// The bus is brought in through a two-flop synchroniser. A run counter measures
// how long the synchronised pattern has been steady. Once it has been steady for
// STABLE_CYCLES samples, the pattern is accepted. An accepted pattern that
// differs from the last one reported produces a one-cycle valid strobe. It also
// updates the hex/blank/err flags and bumps digit_count.
//
// Ports
//   clock        system clock, rising edge
//   resetn       asynchronous active-low reset
//   seg[6:0]     segment bus, active-low, seg[0]=a .. seg[6]=g
//   sample_en    enables qualification; low forces IDLE
//   hex[3:0]     last accepted digit (held across blank/illegal patterns)
//   valid        one-cycle strobe for a newly accepted pattern
//   blank        last accepted pattern was all segments off (7'h7F)
//   err          last accepted pattern was neither a digit nor blank
//   digit_count  number of valid strobes, wraps 255 -> 0
// -----------------------------------------------------------------------------
module seg7_to_hex_encoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [6:0] seg,
    input  logic       sample_en,
    output logic [3:0] hex,
    output logic       valid,
    output logic       blank,
    output logic       err,
    output logic [7:0] digit_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [3:0] STABLE_RUN = 4'(STABLE_CYCLES);
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    // The MSB of last_reg marks "nothing reported yet". No 7-bit bus value
    // can match it, so the first accept after leaving IDLE always reports.
    localparam logic [7:0] LAST_NONE  = 8'h80;

    // Active-low segment codes for digits 0..F, indexed by digit value.
    localparam logic [6:0] DIGIT_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [6:0] sync1_reg;
    logic [6:0] seg_s_reg;
    logic [6:0] seg_p_reg;     // seg_s from the previous cycle
    logic [3:0] run_reg, run_next;
    logic [1:0] state_reg, state_next;
    logic [7:0] last_reg;
    logic [3:0] hex_reg;
    logic       valid_reg;
    logic       blank_reg;
    logic       err_reg;
    logic [7:0] count_reg;

    logic        seg_changed;
    logic        accept;
    logic        report;
    logic [15:0] digit_hit;
    logic        digit_legal;
    logic [3:0]  digit_val;

    // ---------------------------------------------------------------- decode
    for (genvar gi = 0; gi < 16; gi++) begin : g_match
        assign digit_hit[gi] = (seg_s_reg == DIGIT_CODE[gi]);
    end

    // The codes are all distinct, so at most one bit of digit_hit is set.
    always_comb begin
        digit_val = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (digit_hit[i]) begin
                digit_val = 4'(i);
            end
        end
    end

    assign digit_legal = |digit_hit;

    // ------------------------------------------------------ qualification
    assign seg_changed = (seg_s_reg != seg_p_reg);

    always_comb begin
        run_next = run_reg;
        if (!sample_en) begin
            run_next = 4'd0;
        end else if (seg_changed) begin
            run_next = 4'd1;
        end else if (run_reg != 4'hF) begin
            run_next = run_reg + 4'd1;
        end
    end

    // The accept fires on the edge where the run count reaches the threshold.
    // If sample_en is low on that edge, the accept does not happen.
    assign accept = sample_en && (state_reg == ST_SETTLE) && (run_next == STABLE_RUN);
    assign report = accept && ({1'b0, seg_s_reg} != last_reg);

    always_comb begin
        state_next = state_reg;
        if (!sample_en) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   state_next = ST_SETTLE;
                ST_SETTLE: state_next = accept ? ST_HOLD : ST_SETTLE;
                ST_HOLD:   state_next = seg_changed ? ST_SETTLE : ST_HOLD;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_reg <= SEG_BLANK;
            seg_s_reg <= SEG_BLANK;
            seg_p_reg <= SEG_BLANK;
            run_reg   <= 4'd0;
            state_reg <= ST_IDLE;
            last_reg  <= {1'b0, SEG_BLANK};
            hex_reg   <= 4'd0;
            valid_reg <= 1'b0;
            blank_reg <= 1'b0;
            err_reg   <= 1'b0;
            count_reg <= 8'd0;
        end else begin
            sync1_reg <= seg;
            seg_s_reg <= sync1_reg;
            seg_p_reg <= seg_s_reg;
            run_reg   <= run_next;
            state_reg <= state_next;
            valid_reg <= report;

            if (sample_en && (state_reg == ST_IDLE)) begin
                last_reg <= LAST_NONE;
            end else if (report) begin
                last_reg <= {1'b0, seg_s_reg};
            end

            if (report) begin
                count_reg <= count_reg + 8'd1;
                if (digit_legal) begin
                    hex_reg   <= digit_val;
                    blank_reg <= 1'b0;
                    err_reg   <= 1'b0;
                end else if (seg_s_reg == SEG_BLANK) begin
                    blank_reg <= 1'b1;
                    err_reg   <= 1'b0;
                end else begin
                    blank_reg <= 1'b0;
                    err_reg   <= 1'b1;
                end
            end
        end
    end

    assign hex         = hex_reg;
    assign valid       = valid_reg;
    assign blank       = blank_reg;
    assign err         = err_reg;
    assign digit_count = count_reg;

endmodule

// File: tb/tb_seg7_to_hex_encoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_to_hex_encoder
//
// Directed bench for seg7_to_hex_encoder with the default STABLE_CYCLES = 4.
// A clean step to a new pattern is expected to raise valid 6 edges after the
// step. A table of {pattern, expected hex/blank/err} records covers the decode.
// Hand-written sequences cover reset, glitch suppression, sample_en handling
// and the digit_count wrap.
// -----------------------------------------------------------------------------
module tb_seg7_to_hex_encoder;

    localparam int STEP_LATENCY = 6;
    localparam int WAIT_LIMIT   = 20;

    logic       clk;
    logic       resetn;
    logic [6:0] seg;
    logic       sample_en;
    logic [3:0] hex;
    logic       valid;
    logic       blank;
    logic       err;
    logic [7:0] digit_count;

    int         checks;
    int         failures;
    logic [7:0] exp_count;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] hex;
        logic       blank;
        logic       err;
    } vec_t;

    vec_t vecs [20];

    seg7_to_hex_encoder #(.STABLE_CYCLES(4)) dut (
        .clock       (clk),
        .resetn      (resetn),
        .seg         (seg),
        .sample_en   (sample_en),
        .hex         (hex),
        .valid       (valid),
        .blank       (blank),
        .err         (err),
        .digit_count (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Step to the next sample point, 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until valid is seen. A timeout returns -1.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= WAIT_LIMIT; i++) begin
            tick();
            if (valid) begin
                lat = i;
                return;
            end
        end
    endtask

    // Count valid strobes over n cycles.
    task automatic count_valids(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (valid) cnt++;
        end
    endtask

    initial begin
        int lat;
        int cnt;
        int need;
        int timeouts;

        checks    = 0;
        failures  = 0;
        exp_count = 8'd0;

        // Pattern, then expected hex/blank/err. Hex holds across blank and
        // illegal patterns.
        vecs[0]  = '{7'h7F, 4'h2, 1'b1, 1'b0};
        vecs[1]  = '{7'h55, 4'h2, 1'b0, 1'b1};
        vecs[2]  = '{7'h40, 4'h0, 1'b0, 1'b0};
        vecs[3]  = '{7'h79, 4'h1, 1'b0, 1'b0};
        vecs[4]  = '{7'h24, 4'h2, 1'b0, 1'b0};
        vecs[5]  = '{7'h30, 4'h3, 1'b0, 1'b0};
        vecs[6]  = '{7'h19, 4'h4, 1'b0, 1'b0};
        vecs[7]  = '{7'h12, 4'h5, 1'b0, 1'b0};
        vecs[8]  = '{7'h02, 4'h6, 1'b0, 1'b0};
        vecs[9]  = '{7'h78, 4'h7, 1'b0, 1'b0};
        vecs[10] = '{7'h00, 4'h8, 1'b0, 1'b0};
        vecs[11] = '{7'h10, 4'h9, 1'b0, 1'b0};
        vecs[12] = '{7'h08, 4'hA, 1'b0, 1'b0};
        vecs[13] = '{7'h03, 4'hB, 1'b0, 1'b0};
        vecs[14] = '{7'h46, 4'hC, 1'b0, 1'b0};
        vecs[15] = '{7'h21, 4'hD, 1'b0, 1'b0};
        vecs[16] = '{7'h06, 4'hE, 1'b0, 1'b0};
        vecs[17] = '{7'h0E, 4'hF, 1'b0, 1'b0};
        vecs[18] = '{7'h7E, 4'hF, 1'b0, 1'b1};
        vecs[19] = '{7'h7F, 4'hF, 1'b1, 1'b0};

        // ---- Reset, then a clean step to 2 ---------------------------------
        resetn    = 1'b0;
        sample_en = 1'b1;
        seg       = 7'h24;
        tick();
        tick();
        chk("reset_hex",   hex,         0);
        chk("reset_valid", valid,       0);
        chk("reset_blank", blank,       0);
        chk("reset_err",   err,         0);
        chk("reset_count", digit_count, 0);
        resetn = 1'b1;
        wait_valid(lat);
        exp_count++;
        $display("step seg=24 latency=%0d hex=%0h count=%0d", lat, hex, digit_count);
        chk("first_latency", lat, STEP_LATENCY);
        chk("first_hex",     hex, 2);
        chk("first_err",     err, 0);
        chk("first_blank",   blank, 0);
        chk("first_count",   digit_count, exp_count);
        tick();
        chk("first_valid_one_cycle", valid, 0);

        // ---- Short glitch to 30, back to 24: no re-report ------------------
        seg = 7'h30;
        tick();
        tick();
        seg = 7'h24;
        count_valids(15, cnt);
        $display("glitch 30x2 valids=%0d hex=%0h count=%0d", cnt, hex, digit_count);
        chk("glitch_valids", cnt, 0);
        chk("glitch_hex",    hex, 2);
        chk("glitch_count",  digit_count, exp_count);

        // ---- Table: blank, illegal, all 16 digits, more illegal/blank ------
        for (int v = 0; v < 20; v++) begin
            seg = vecs[v].seg;
            wait_valid(lat);
            exp_count++;
            $display("vec %0d seg=%02h latency=%0d hex=%0h blank=%0b err=%0b count=%0d",
                     v, vecs[v].seg, lat, hex, blank, err, digit_count);
            chk($sformatf("vec%0d_latency", v), lat, STEP_LATENCY);
            chk($sformatf("vec%0d_hex", v),     hex, vecs[v].hex);
            chk($sformatf("vec%0d_blank", v),   blank, vecs[v].blank);
            chk($sformatf("vec%0d_err", v),     err, vecs[v].err);
            chk($sformatf("vec%0d_count", v),   digit_count, exp_count);
            tick();
            chk($sformatf("vec%0d_valid_one_cycle", v), valid, 0);
        end

        // ---- Reset pulse during SETTLE with A on the bus -------------------
        seg = 7'h08;
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        $display("async reset hex=%0h blank=%0b count=%0d", hex, blank, digit_count);
        chk("async_reset_blank", blank, 0);
        chk("async_reset_count", digit_count, 0);
        tick();
        resetn    = 1'b1;
        exp_count = 8'd0;
        wait_valid(lat);
        exp_count++;
        $display("after reset seg=08 latency=%0d hex=%0h count=%0d", lat, hex, digit_count);
        chk("post_reset_latency", lat, STEP_LATENCY);
        chk("post_reset_hex",     hex, 10);
        chk("post_reset_count",   digit_count, exp_count);

        // ---- sample_en low then high re-reports an unchanged 1 -------------
        seg = 7'h79;
        wait_valid(lat);
        exp_count++;
        chk("en_first_hex", hex, 1);
        sample_en = 1'b0;
        count_valids(3, cnt);
        chk("en_low_valids", cnt, 0);
        chk("en_low_hex_hold", hex, 1);
        sample_en = 1'b1;
        wait_valid(lat);
        exp_count++;
        $display("sample_en toggle seg=79 latency=%0d hex=%0h count=%0d", lat, hex, digit_count);
        chk("en_rereport_seen",  (lat > 0) ? 1 : 0, 1);
        chk("en_rereport_hex",   hex, 1);
        chk("en_rereport_count", digit_count, exp_count);

        // ---- sample_en falls on the accept edge: no valid ------------------
        seg = 7'h40;
        for (int i = 0; i < STEP_LATENCY - 1; i++) tick();
        sample_en = 1'b0;
        count_valids(10, cnt);
        $display("en drop on accept edge valids=%0d hex=%0h", cnt, hex);
        chk("accept_edge_drop_valids", cnt, 0);
        chk("accept_edge_drop_hex",    hex, 1);
        sample_en = 1'b1;
        wait_valid(lat);
        exp_count++;
        chk("accept_edge_resume_hex",   hex, 0);
        chk("accept_edge_resume_count", digit_count, exp_count);

        // ---- Run accepts until digit_count wraps to 0 ----------------------
        need     = 256 - int'(exp_count);
        timeouts = 0;
        for (int k = 0; k < need; k++) begin
            seg = (k % 2 == 0) ? 7'h79 : 7'h40;
            wait_valid(lat);
            if (lat < 0) timeouts++;
            exp_count++;
            tick();
        end
        $display("wrap accepts=%0d count=%0d timeouts=%0d", need, digit_count, timeouts);
        chk("wrap_timeouts", timeouts, 0);
        chk("wrap_count",    digit_count, 0);
        chk("wrap_hex",      hex, (need % 2 == 1) ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_to_hex_encoder.md
Name: seg7_to_hex_encoder

Overview:
- Reverse of the board's hex-to-seven-segment path: watches an active-low 7-segment bus and recovers the 4-bit hex digit it shows.
- Synchronises the bus and waits until the pattern has been steady for a set number of cycles.
- Then reports the digit with a one-cycle valid strobe, and flags illegal and blank patterns.
- Used as a loopback checker on display outputs and as an input decoder for segment-coded sources.

Parameters:
STABLE_CYCLES, 4, number of consecutive equal synchronised samples required before a pattern is accepted (legal range 2..15)

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
seg  input  7  segment bus, active-low, seg[0]=a … seg[6]=g
sample_en  input  1  enables qualification; low forces IDLE
hex  output  4  last accepted digit
valid  output  1  one-cycle strobe: new accepted pattern
blank  output  1  last accepted pattern was all-off (7'h7F)
err  output  1  last accepted pattern was not a legal digit or blank
digit_count  output  8  count of valid strobes, wraps 255->0

Behaviour:
Reset:
- Asynchronous on resetn low.
- All outputs 0, sync flops 7'h7F, run counter 0, last-reported register 7'h7F, state IDLE.
- Reset mid-qualification discards everything; no valid pulse afterwards until a fresh qualification completes.

Synchroniser and run counter:
- seg passes through two flops to give seg_s.
- Run counter: at each edge with sample_en high, if seg_s equals its previous-cycle value, run saturates upward; otherwise run <= 1.

States: IDLE, SETTLE, HOLD.
- IDLE: entered whenever sample_en is low. Run is 0, valid is 0, hex/blank/err hold. When sample_en rises, go to SETTLE and clear last-reported to an invalid marker so the next accept always reports.
- SETTLE -> HOLD: when run reaches STABLE_CYCLES. The accept occurs on that edge.
- HOLD -> SETTLE: on any seg_s change.
- Clean step: a clean input step with sample_en high gives valid exactly 2+STABLE_CYCLES edges after the step edge (6 for the default).

Accept:
- If the pattern equals last-reported, no valid and no output change. This suppresses re-reporting after a short glitch.
- Otherwise: valid=1 for one cycle, digit_count increments, last-reported <= pattern, and the pattern is decoded as below.

Decode (seg[6:0], active-low):
- Legal digits: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- Legal digit: hex=digit, err=0, blank=0.
- 7F: blank=1, err=0, hex holds.
- Any other pattern: err=1, blank=0, hex holds.

Boundary rules:
- A change before run reaches STABLE_CYCLES restarts the count; no valid.
- sample_en falling on the accept edge: the accept is suppressed and the block enters IDLE.
- digit_count wraps 255->0 with no flag.

Test Plan:
1. Reset, sample_en=1, seg=7'h24 held -> valid high exactly 6 edges after the step, hex=2, err=0, blank=0, digit_count=1.
2. Present 7'h24 stable, then 7'h30 for 2 cycles, then back to 7'h24 -> no second valid; hex stays 2; digit_count stays 1.
3. Step to 7'h7F, then to 7'h55 -> first: valid, blank=1, hex unchanged; second: valid, err=1, blank=0, hex unchanged.
4. Cycle all 16 legal codes, each held 10 cycles -> 16 valids, hex sequence 0..F, err never set.
5. Assert resetn low for 1 cycle during SETTLE with 7'h08 present -> outputs 0 immediately; valid with hex=A 6 edges after resetn release.
6. Toggle sample_en low then high with seg=7'h79 unchanged -> valid re-reported (hex=1). Run 256 accepts -> digit_count wraps to 0.
